// File: rtl/comet_mem_pkg.sv
// rtl/comet_mem_pkg.sv - shared owner codes and read-latency limits for the COMET II RAM arbiter
//
// Purpose: owner encoding used by the arbitration channels and the read-return tag pipe,
//          plus the legal range of RAM read latency.
// Ports:   none (package).
package comet_mem_pkg;

  typedef enum logic {
    OWN_CPU  = 1'b0,
    OWN_HOST = 1'b1
  } owner_e;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  function automatic bit rd_lat_ok(input int lat);
    return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
  endfunction

endpackage

// File: rtl/comet_arb_chan.sv
// rtl/comet_arb_chan.sv - one arbitration channel (winner select, burst accounting, operand mux)
//
// Purpose: picks the winner between CPU and host for one RAM port each cycle, drives the
//          grants combinationally and muxes the winner's operand (address, or address+data)
//          onto the RAM side. With no request the operand output holds its last value.
// Build:   COMET_ARB_RR_EN defined   -> round-robin with MAX_BURST burst limit
//          COMET_ARB_RR_EN undefined -> fixed priority, host wins every contention
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_cpu_req, i_cpu_op     CPU request and operand
//   i_host_req, i_host_op   host request and operand
//   o_cpu_gnt, o_host_gnt   per-cycle grants
//   o_en                    RAM enable (some request accepted)
//   o_op                    winner's operand, or last granted operand when idle
module comet_arb_chan
  import comet_mem_pkg::*;
#(
  parameter int OW        = 16,
  parameter int MAX_BURST = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_cpu_req,
  input  logic [OW-1:0] i_cpu_op,
  input  logic          i_host_req,
  input  logic [OW-1:0] i_host_op,
  output logic          o_cpu_gnt,
  output logic          o_host_gnt,
  output logic          o_en,
  output logic [OW-1:0] o_op
);

  if (MAX_BURST < 1) begin : g_bad_burst
    $error("comet_arb_chan: MAX_BURST must be >= 1");
  end

  // Requests are masked during reset so no grant can leak out while rst is high.
  logic          w_cpu_req;
  logic          w_host_req;
  owner_e        w_winner;
  logic [OW-1:0] w_sel_op;
  logic [OW-1:0] r_op;

  assign w_cpu_req  = i_cpu_req & ~i_rst;
  assign w_host_req = i_host_req & ~i_rst;

`ifdef COMET_ARB_RR_EN
  localparam int CW = $clog2(MAX_BURST + 1);

  owner_e        r_last_owner;
  logic [CW-1:0] r_burst_cnt;
  logic          w_both;
  logic          w_yield;

  assign w_both  = w_cpu_req & w_host_req;
  assign w_yield = w_both && (r_burst_cnt >= CW'(MAX_BURST));

  always_comb begin
    w_winner = OWN_CPU;
    if (w_both) begin
      w_winner = w_yield ? owner_e'(~r_last_owner) : r_last_owner;
    end else if (w_host_req) begin
      w_winner = OWN_HOST;
    end
  end

  // The yield slot hands the other side a single grant but does not transfer burst
  // ownership: the burst owner resumes afterwards with a fresh count.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_last_owner <= OWN_CPU;
      r_burst_cnt  <= '0;
    end else if (w_both) begin
      if (w_yield) begin
        r_burst_cnt <= '0;
      end else if (r_burst_cnt < CW'(MAX_BURST)) begin
        r_burst_cnt <= r_burst_cnt + CW'(1);
      end
    end else begin
      r_burst_cnt <= '0;
      if (w_cpu_req || w_host_req) begin
        r_last_owner <= w_winner;
      end
    end
  end
`else
  always_comb begin
    w_winner = OWN_CPU;
    if (w_host_req) begin
      w_winner = OWN_HOST;
    end
  end
`endif

  assign o_cpu_gnt  = w_cpu_req && (w_winner == OWN_CPU);
  assign o_host_gnt = w_host_req && (w_winner == OWN_HOST);
  assign o_en       = w_cpu_req | w_host_req;
  assign w_sel_op   = (w_winner == OWN_HOST) ? i_host_op : i_cpu_op;
  assign o_op       = o_en ? w_sel_op : r_op;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_op <= '0;
    end else if (o_en) begin
      r_op <= w_sel_op;
    end
  end

endmodule

// File: rtl/comet_mem_arbiter.sv
// rtl/comet_mem_arbiter.sv - CPU/host arbiter in front of the COMET II test RAM
//
// Purpose: independent read and write arbitration between the CPU and the host/debug port,
//          plus an RD_LAT-deep owner-tag pipe that steers returning read data to the port
//          that issued the read.
// Build:   COMET_ARB_RR_EN selects round-robin with burst limit; undefined = host priority.
// Ports:
//   i_mclk, i_rst                               clock, asynchronous active-high reset
//   i_cpu_re/i_cpu_raddr, o_cpu_rgnt            CPU read request / accept
//   o_cpu_rvalid, o_cpu_rdata                   CPU read return
//   i_cpu_we/i_cpu_waddr/i_cpu_wdata, o_cpu_wgnt CPU write request / accept
//   i_host_* / o_host_*                         same set for the host port
//   o_mem_re, o_mem_raddr, i_mem_rdata          RAM read port
//   o_mem_we, o_mem_waddr, o_mem_wdata          RAM write port
module comet_mem_arbiter
  import comet_mem_pkg::*;
#(
  parameter int AW        = 16,
  parameter int DW        = 16,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 8
) (
  input  logic          i_mclk,
  input  logic          i_rst,
  input  logic          i_cpu_re,
  input  logic [AW-1:0] i_cpu_raddr,
  output logic          o_cpu_rgnt,
  output logic          o_cpu_rvalid,
  output logic [DW-1:0] o_cpu_rdata,
  input  logic          i_cpu_we,
  input  logic [AW-1:0] i_cpu_waddr,
  input  logic [DW-1:0] i_cpu_wdata,
  output logic          o_cpu_wgnt,
  input  logic          i_host_re,
  input  logic [AW-1:0] i_host_raddr,
  output logic          o_host_rgnt,
  output logic          o_host_rvalid,
  output logic [DW-1:0] o_host_rdata,
  input  logic          i_host_we,
  input  logic [AW-1:0] i_host_waddr,
  input  logic [DW-1:0] i_host_wdata,
  output logic          o_host_wgnt,
  output logic          o_mem_re,
  output logic [AW-1:0] o_mem_raddr,
  input  logic [DW-1:0] i_mem_rdata,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_waddr,
  output logic [DW-1:0] o_mem_wdata
);

  if (!rd_lat_ok(RD_LAT)) begin : g_bad_rd_lat
    $error("comet_mem_arbiter: RD_LAT out of range");
  end

  logic [AW+DW-1:0] w_wr_op;
  logic [RD_LAT-1:0] r_tag_vld;
  owner_e            r_tag_own [RD_LAT];

  comet_arb_chan #(
    .OW        (AW),
    .MAX_BURST (MAX_BURST)
  ) u_rd_chan (
    .i_clk      (i_mclk),
    .i_rst      (i_rst),
    .i_cpu_req  (i_cpu_re),
    .i_cpu_op   (i_cpu_raddr),
    .i_host_req (i_host_re),
    .i_host_op  (i_host_raddr),
    .o_cpu_gnt  (o_cpu_rgnt),
    .o_host_gnt (o_host_rgnt),
    .o_en       (o_mem_re),
    .o_op       (o_mem_raddr)
  );

  comet_arb_chan #(
    .OW        (AW + DW),
    .MAX_BURST (MAX_BURST)
  ) u_wr_chan (
    .i_clk      (i_mclk),
    .i_rst      (i_rst),
    .i_cpu_req  (i_cpu_we),
    .i_cpu_op   ({i_cpu_waddr, i_cpu_wdata}),
    .i_host_req (i_host_we),
    .i_host_op  ({i_host_waddr, i_host_wdata}),
    .o_cpu_gnt  (o_cpu_wgnt),
    .o_host_gnt (o_host_wgnt),
    .o_en       (o_mem_we),
    .o_op       (w_wr_op)
  );

  assign o_mem_waddr = w_wr_op[AW+DW-1:DW];
  assign o_mem_wdata = w_wr_op[DW-1:0];

  // Owner tag travels alongside the RAM's own read pipeline; one issue per cycle at most,
  // so returns come back in issue order with no bubbles.
  always_ff @(posedge i_mclk or posedge i_rst) begin
    if (i_rst) begin
      r_tag_vld <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        r_tag_own[i] <= OWN_CPU;
      end
    end else begin
      r_tag_vld[0] <= o_mem_re;
      r_tag_own[0] <= o_host_rgnt ? OWN_HOST : OWN_CPU;
      for (int i = 1; i < RD_LAT; i++) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
        r_tag_own[i] <= r_tag_own[i-1];
      end
    end
  end

  assign o_cpu_rvalid  = r_tag_vld[RD_LAT-1] && (r_tag_own[RD_LAT-1] == OWN_CPU);
  assign o_host_rvalid = r_tag_vld[RD_LAT-1] && (r_tag_own[RD_LAT-1] == OWN_HOST);
  assign o_cpu_rdata   = i_mem_rdata;
  assign o_host_rdata  = i_mem_rdata;

endmodule

// File: tb/tb_comet_mem_arbiter.sv
// tb/tb_comet_mem_arbiter.sv - directed self-checking bench for comet_mem_arbiter (RD_LAT 1 and 3)
module tb_comet_mem_arbiter;

`ifdef COMET_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        cpu_re, cpu_we, host_re, host_we;
  logic [15:0] cpu_raddr, cpu_waddr, cpu_wdata, host_raddr, host_waddr, host_wdata;

  logic        d1_cpu_rgnt, d1_cpu_rvalid, d1_cpu_wgnt, d1_host_rgnt, d1_host_rvalid, d1_host_wgnt;
  logic        d1_mem_re, d1_mem_we;
  logic [15:0] d1_cpu_rdata, d1_host_rdata, d1_mem_raddr, d1_mem_waddr, d1_mem_wdata, d1_mem_rdata;

  logic        d3_cpu_rgnt, d3_cpu_rvalid, d3_cpu_wgnt, d3_host_rgnt, d3_host_rvalid, d3_host_wgnt;
  logic        d3_mem_re, d3_mem_we;
  logic [15:0] d3_cpu_rdata, d3_host_rdata, d3_mem_raddr, d3_mem_waddr, d3_mem_wdata, d3_mem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [15:0] ram_val(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  comet_mem_arbiter #(.AW(16), .DW(16), .RD_LAT(1), .MAX_BURST(8)) u_dut1 (
    .i_mclk(clk), .i_rst(rst),
    .i_cpu_re(cpu_re), .i_cpu_raddr(cpu_raddr), .o_cpu_rgnt(d1_cpu_rgnt),
    .o_cpu_rvalid(d1_cpu_rvalid), .o_cpu_rdata(d1_cpu_rdata),
    .i_cpu_we(cpu_we), .i_cpu_waddr(cpu_waddr), .i_cpu_wdata(cpu_wdata), .o_cpu_wgnt(d1_cpu_wgnt),
    .i_host_re(host_re), .i_host_raddr(host_raddr), .o_host_rgnt(d1_host_rgnt),
    .o_host_rvalid(d1_host_rvalid), .o_host_rdata(d1_host_rdata),
    .i_host_we(host_we), .i_host_waddr(host_waddr), .i_host_wdata(host_wdata), .o_host_wgnt(d1_host_wgnt),
    .o_mem_re(d1_mem_re), .o_mem_raddr(d1_mem_raddr), .i_mem_rdata(d1_mem_rdata),
    .o_mem_we(d1_mem_we), .o_mem_waddr(d1_mem_waddr), .o_mem_wdata(d1_mem_wdata)
  );

  comet_mem_arbiter #(.AW(16), .DW(16), .RD_LAT(3), .MAX_BURST(8)) u_dut3 (
    .i_mclk(clk), .i_rst(rst),
    .i_cpu_re(cpu_re), .i_cpu_raddr(cpu_raddr), .o_cpu_rgnt(d3_cpu_rgnt),
    .o_cpu_rvalid(d3_cpu_rvalid), .o_cpu_rdata(d3_cpu_rdata),
    .i_cpu_we(cpu_we), .i_cpu_waddr(cpu_waddr), .i_cpu_wdata(cpu_wdata), .o_cpu_wgnt(d3_cpu_wgnt),
    .i_host_re(host_re), .i_host_raddr(host_raddr), .o_host_rgnt(d3_host_rgnt),
    .o_host_rvalid(d3_host_rvalid), .o_host_rdata(d3_host_rdata),
    .i_host_we(host_we), .i_host_waddr(host_waddr), .i_host_wdata(host_wdata), .o_host_wgnt(d3_host_wgnt),
    .o_mem_re(d3_mem_re), .o_mem_raddr(d3_mem_raddr), .i_mem_rdata(d3_mem_rdata),
    .o_mem_we(d3_mem_we), .o_mem_waddr(d3_mem_waddr), .o_mem_wdata(d3_mem_wdata)
  );

  // RAM models: read data is a fixed function of the address, delivered RD_LAT cycles later.
  logic [15:0] ram3_pipe [3];

  always @(posedge clk) begin
    d1_mem_rdata <= d1_mem_re ? ram_val(d1_mem_raddr) : 16'hDEAD;
    ram3_pipe[0] <= d3_mem_re ? ram_val(d3_mem_raddr) : 16'hDEAD;
    ram3_pipe[1] <= ram3_pipe[0];
    ram3_pipe[2] <= ram3_pipe[1];
  end
  assign d3_mem_rdata = ram3_pipe[2];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    cpu_re = 1'b0; cpu_we = 1'b0; host_re = 1'b0; host_we = 1'b0;
  endtask

  initial begin
    logic exp_host;
    int   j;

    rst = 1'b1;
    cpu_re = 1'b1; cpu_we = 1'b1; host_re = 1'b1; host_we = 1'b1;
    cpu_raddr = 16'h0011; host_raddr = 16'h0022;
    cpu_waddr = 16'h0033; host_waddr = 16'h0044;
    cpu_wdata = 16'h0001; host_wdata = 16'h0002;
    repeat (2) tick();

    // 1: reset with everything requesting
    check_eq("rst_cpu_rgnt",  d1_cpu_rgnt, 0);
    check_eq("rst_host_rgnt", d1_host_rgnt, 0);
    check_eq("rst_cpu_wgnt",  d1_cpu_wgnt, 0);
    check_eq("rst_host_wgnt", d1_host_wgnt, 0);
    check_eq("rst_mem_re",    d1_mem_re, 0);
    check_eq("rst_mem_we",    d1_mem_we, 0);
    check_eq("rst_cpu_rvalid", d1_cpu_rvalid, 0);
    check_eq("rst_host_rvalid", d3_host_rvalid, 0);
    check_eq("rst_mem_raddr", d1_mem_raddr, 0);
    check_eq("rst_mem_wdata", d1_mem_wdata, 0);
    rst = 1'b0;
    #1;
    check_eq("rel_cpu_rgnt",  d1_cpu_rgnt, RR);
    check_eq("rel_host_rgnt", d1_host_rgnt, !RR);
    check_eq("rel_cpu_wgnt",  d1_cpu_wgnt, RR);
    tick();
    idle_all();
    repeat (5) tick();

    // 2: lone CPU read, RD_LAT=1
    cpu_re = 1'b1; cpu_raddr = 16'h0010;
    #1;
    check_eq("t2_cpu_rgnt",  d1_cpu_rgnt, 1);
    check_eq("t2_host_rgnt", d1_host_rgnt, 0);
    check_eq("t2_mem_re",    d1_mem_re, 1);
    check_eq("t2_mem_raddr", d1_mem_raddr, 16'h0010);
    tick();
    cpu_re = 1'b0;
    #1;
    check_eq("t2_cpu_rvalid",  d1_cpu_rvalid, 1);
    check_eq("t2_cpu_rdata",   d1_cpu_rdata, ram_val(16'h0010));
    check_eq("t2_host_rvalid", d1_host_rvalid, 0);
    check_eq("t2_idle_mem_re", d1_mem_re, 0);
    check_eq("t2_hold_raddr",  d1_mem_raddr, 16'h0010);
    tick();
    check_eq("t2_rvalid_once", d1_cpu_rvalid, 0);

    // 3: host write and CPU read of the same address in one cycle
    host_we = 1'b1; host_waddr = 16'h0020; host_wdata = 16'hBEEF;
    cpu_re = 1'b1; cpu_raddr = 16'h0020;
    #1;
    check_eq("t3_host_wgnt", d1_host_wgnt, 1);
    check_eq("t3_cpu_rgnt",  d1_cpu_rgnt, 1);
    check_eq("t3_mem_we",    d1_mem_we, 1);
    check_eq("t3_mem_waddr", d1_mem_waddr, 16'h0020);
    check_eq("t3_mem_wdata", d1_mem_wdata, 16'hBEEF);
    check_eq("t3_mem_raddr", d1_mem_raddr, 16'h0020);
    check_eq("t3_cpu_wgnt",  d1_cpu_wgnt, 0);
    check_eq("t3_host_rgnt", d1_host_rgnt, 0);
    tick();
    idle_all();
    // write contention: host was the last write owner, so it wins in both modes
    cpu_we = 1'b1; cpu_waddr = 16'h0030; cpu_wdata = 16'h1111;
    host_we = 1'b1; host_waddr = 16'h0031; host_wdata = 16'h2222;
    #1;
    check_eq("t3w_host_wgnt", d1_host_wgnt, 1);
    check_eq("t3w_cpu_wgnt",  d1_cpu_wgnt, 0);
    check_eq("t3w_mem_wdata", d1_mem_wdata, 16'h2222);
    tick();
    idle_all();
    tick();
    check_eq("t3w_hold_waddr", d1_mem_waddr, 16'h0031);
    repeat (4) tick();

    // 4: both reading continuously, host as current owner
    host_re = 1'b1; host_raddr = 16'h0040; cpu_raddr = 16'h0041;
    tick();
    cpu_re = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      exp_host = RR ? ((i % 9) != 8) : 1'b1;
      check_eq($sformatf("t4_host_rgnt_%0d", i), d1_host_rgnt, exp_host);
      check_eq($sformatf("t4_cpu_rgnt_%0d", i), d1_cpu_rgnt, !exp_host);
      check_eq($sformatf("t4_mem_raddr_%0d", i), d1_mem_raddr, exp_host ? 16'h0040 : 16'h0041);
      tick();
    end
    idle_all();
    repeat (5) tick();

    // 5: alternating CPU/host reads, RD_LAT=3
    for (int c = 0; c < 10; c++) begin
      if (c < 6) begin
        cpu_re = (c % 2) == 0;
        host_re = (c % 2) == 1;
        cpu_raddr = 16'h0100 + 16'(c);
        host_raddr = 16'h0100 + 16'(c);
      end else begin
        idle_all();
      end
      #1;
      tick();
      j = c + 1 - 3;
      if (j >= 0 && j < 6) begin
        check_eq($sformatf("t5_cpu_rvalid_%0d", c), d3_cpu_rvalid, (j % 2) == 0);
        check_eq($sformatf("t5_host_rvalid_%0d", c), d3_host_rvalid, (j % 2) == 1);
        check_eq($sformatf("t5_rdata_%0d", c), d3_cpu_rdata, ram_val(16'h0100 + 16'(j)));
      end else begin
        check_eq($sformatf("t5_cpu_idle_%0d", c), d3_cpu_rvalid, 0);
        check_eq($sformatf("t5_host_idle_%0d", c), d3_host_rvalid, 0);
      end
    end
    idle_all();
    repeat (4) tick();

    // 6: reset with two reads in flight
    cpu_re = 1'b1; cpu_raddr = 16'h0050;
    tick();
    cpu_re = 1'b0; host_re = 1'b1; host_raddr = 16'h0051;
    tick();
    host_re = 1'b0;
    #2;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check_eq($sformatf("t6_cpu_quiet_%0d", k), d3_cpu_rvalid, 0);
      check_eq($sformatf("t6_host_quiet_%0d", k), d3_host_rvalid, 0);
      tick();
    end
    cpu_re = 1'b1; cpu_raddr = 16'h0033;
    tick();
    cpu_re = 1'b0;
    tick();
    tick();
    check_eq("t6_after_rvalid", d3_cpu_rvalid, 1);
    check_eq("t6_after_rdata",  d3_cpu_rdata, ram_val(16'h0033));
    check_eq("t6_after_host",   d3_host_rvalid, 0);
    tick();
    check_eq("t6_after_once",   d3_cpu_rvalid, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
